// File: rtl/velocity_pkg.sv
// -----------------------------------------------------------------------------
// velocity_pkg
// Shared definitions for the per-cell velocity streamer:
//   - vel_state_e      : controller FSM states
//   - VEL_COMP_WIDTH   : width of one velocity component (vx, vy, vz)
//   - VEL_DATA_WIDTH   : default width of one {vz, vy, vx} RAM word
//   - VEL_ADDR_WIDTH   : default RAM address width
//   - VEL_PARTICLE_NUM : default RAM depth (count word + particles)
//   - VEL_CNT_LSB      : bit position of the particle count inside word 0
// -----------------------------------------------------------------------------
package velocity_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_CNT   = 3'd1,
      ST_WAIT_CNT = 3'd2,
      ST_STREAM   = 3'd3,
      ST_DRAIN    = 3'd4
   } vel_state_e;

   localparam int VEL_COMP_WIDTH   = 32;
   localparam int VEL_DATA_WIDTH   = 3 * VEL_COMP_WIDTH;
   localparam int VEL_ADDR_WIDTH   = 8;
   localparam int VEL_PARTICLE_NUM = 220;
   localparam int VEL_CNT_LSB      = 0;

endpackage

// File: rtl/velocity_skid_fifo.sv
// -----------------------------------------------------------------------------
// velocity_skid_fifo
// Two-entry FIFO of {pid, data}. Entry 0 (head) is always the oldest word and
// drives the outputs directly from flops, so the visible word only changes on
// a pop. The producer must guarantee it never pushes into a full FIFO unless
// a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_pid,
//   push_data             write one entry
//   pop                   remove the head entry (ignored when empty)
//   head_pid, head_data   oldest entry
//   occupancy             number of valid entries (0..2)
//   not_empty             occupancy != 0
// -----------------------------------------------------------------------------
module velocity_skid_fifo #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_pid,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] head_pid,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [1:0]            occupancy,
   output logic                  not_empty
);

   logic [ADDR_WIDTH-1:0] tail_pid;
   logic [DATA_WIDTH-1:0] tail_data;
   logic                  pop_ok;
   logic                  push_ok;

   assign pop_ok    = pop && (occupancy != 2'd0);
   assign push_ok   = push && ((occupancy != 2'd2) || pop_ok);
   assign not_empty = (occupancy != 2'd0);

   // Storage and occupancy update; head shifts from tail on pop when full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= 2'd0;
         head_pid  <= '0;
         head_data <= '0;
         tail_pid  <= '0;
         tail_data <= '0;
      end else begin
         case (occupancy)
            2'd0: begin
               if (push_ok) begin
                  head_pid  <= push_pid;
                  head_data <= push_data;
                  occupancy <= 2'd1;
               end
            end
            2'd1: begin
               if (push_ok && pop_ok) begin
                  head_pid  <= push_pid;
                  head_data <= push_data;
               end else if (push_ok) begin
                  tail_pid  <= push_pid;
                  tail_data <= push_data;
                  occupancy <= 2'd2;
               end else if (pop_ok) begin
                  occupancy <= 2'd0;
               end
            end
            2'd2: begin
               if (pop_ok) begin
                  head_pid  <= tail_pid;
                  head_data <= tail_data;
                  if (push_ok) begin
                     tail_pid  <= push_pid;
                     tail_data <= push_data;
                  end else begin
                     occupancy <= 2'd1;
                  end
               end
            end
            default: begin
               occupancy <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/velocity_cell_streamer.sv
// -----------------------------------------------------------------------------
// velocity_cell_streamer
// Fronts one cell's single-port velocity RAM (word 0 = particle count, words
// 1..N = {vz, vy, vx}). On start it reads the count and streams every particle
// word out under valid/ready backpressure; while idle it accepts write-backs.
//
// Optional feature: define VELOCITY_COUNT_CLAMP_EN to clamp an out-of-range
// count to PARTICLE_NUM-1 and raise the sticky count_err output.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle sweep request (honoured only in IDLE)
//   busy, done                  not-IDLE flag, end-of-sweep pulse
//   count                       particle count of the current/last sweep
//   count_err                   (clamp build only) count was clamped
//   out_valid/out_ready,
//   out_data/out_pid            velocity stream and its RAM address
//   wb_valid/wb_ready,
//   wb_addr/wb_data             write-back port (IDLE only)
//   ram_address/ram_data,
//   ram_rden/ram_wren/ram_q     RAM port, 1-cycle read latency
// -----------------------------------------------------------------------------
module velocity_cell_streamer
   import velocity_pkg::*;
#(
   parameter int DATA_WIDTH   = VEL_DATA_WIDTH,
   parameter int ADDR_WIDTH   = VEL_ADDR_WIDTH,
   parameter int PARTICLE_NUM = VEL_PARTICLE_NUM
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] count,
`ifdef VELOCITY_COUNT_CLAMP_EN
   output logic                  count_err,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_pid,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_rden,
   output logic                  ram_wren,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   vel_state_e            state;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  rd_pend;      // a data read is returning on ram_q
   logic [ADDR_WIDTH-1:0] rd_pend_pid;
   logic                  wb_en;        // keeps wb_ready low while in reset
   logic [1:0]            occ;
   logic                  pop;
   logic [2:0]            eff_load;
   logic                  credit;
   logic                  data_issue;
   logic [ADDR_WIDTH-1:0] issue_pid;
   logic [ADDR_WIDTH-1:0] raw_cnt;
   logic [ADDR_WIDTH-1:0] cnt_sel;

   assign raw_cnt = ram_q[VEL_CNT_LSB +: ADDR_WIDTH];

`ifdef VELOCITY_COUNT_CLAMP_EN
   localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);
   logic cnt_over;
   assign cnt_over = (raw_cnt > CNT_MAX);
   assign cnt_sel  = cnt_over ? CNT_MAX : raw_cnt;
`else
   assign cnt_sel  = raw_cnt;
`endif

   assign pop = out_valid && out_ready;

   // A word leaving this cycle frees its slot in time for a read issued now,
   // which is what sustains one word per cycle with out_ready held high.
   assign eff_load = {1'b0, occ} - {2'b00, pop} + {2'b00, rd_pend};
   assign credit   = (eff_load < 3'd2);

   // RAM port and write-back handshake. The count word is on ram_q during
   // WAIT_CNT, so the read of particle 1 is launched there when count != 0.
   always_comb begin
      ram_rden    = 1'b0;
      ram_wren    = 1'b0;
      ram_address = '0;
      ram_data    = '0;
      wb_ready    = 1'b0;
      data_issue  = 1'b0;
      issue_pid   = '0;
      case (state)
         ST_IDLE: begin
            wb_ready = wb_en && !start;
            if (wb_valid && wb_en && !start) begin
               ram_wren    = 1'b1;
               ram_address = wb_addr;
               ram_data    = wb_data;
            end else begin
               ram_wren    = 1'b0;
            end
         end
         ST_RD_CNT: begin
            ram_rden    = 1'b1;
            ram_address = '0;
         end
         ST_WAIT_CNT: begin
            if (cnt_sel != '0) begin
               ram_rden    = 1'b1;
               ram_address = ADDR_WIDTH'(1);
               data_issue  = 1'b1;
               issue_pid   = ADDR_WIDTH'(1);
            end else begin
               ram_rden    = 1'b0;
            end
         end
         ST_STREAM: begin
            if (credit) begin
               ram_rden    = 1'b1;
               ram_address = rd_ptr;
               data_issue  = 1'b1;
               issue_pid   = rd_ptr;
            end else begin
               ram_rden    = 1'b0;
            end
         end
         ST_DRAIN: begin
            ram_rden = 1'b0;
         end
         default: begin
            ram_rden = 1'b0;
         end
      endcase
   end

   // Controller FSM with registered busy/done/count and read tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         count       <= '0;
         rd_ptr      <= '0;
         rd_pend     <= 1'b0;
         rd_pend_pid <= '0;
         wb_en       <= 1'b0;
`ifdef VELOCITY_COUNT_CLAMP_EN
         count_err   <= 1'b0;
`endif
      end else begin
         wb_en       <= 1'b1;
         done        <= 1'b0;
         rd_pend     <= data_issue;
         rd_pend_pid <= issue_pid;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RD_CNT;
                  busy  <= 1'b1;
`ifdef VELOCITY_COUNT_CLAMP_EN
                  count_err <= 1'b0;
`endif
               end
            end
            ST_RD_CNT: begin
               state <= ST_WAIT_CNT;
            end
            ST_WAIT_CNT: begin
               count <= cnt_sel;
`ifdef VELOCITY_COUNT_CLAMP_EN
               count_err <= cnt_over;
`endif
               if (cnt_sel == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (cnt_sel == ADDR_WIDTH'(1)) begin
                  state <= ST_DRAIN;
               end else begin
                  state  <= ST_STREAM;
                  rd_ptr <= ADDR_WIDTH'(2);
               end
            end
            ST_STREAM: begin
               if (data_issue) begin
                  if (rd_ptr == count) begin
                     state <= ST_DRAIN;
                  end else begin
                     rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                  end
               end
            end
            ST_DRAIN: begin
               // Finish on the cycle the last word leaves the FIFO.
               if (!rd_pend && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   velocity_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_pend),
      .push_pid  (rd_pend_pid),
      .push_data (ram_q),
      .pop       (pop),
      .head_pid  (out_pid),
      .head_data (out_data),
      .occupancy (occ),
      .not_empty (out_valid)
   );

endmodule

// File: tb/tb_velocity_cell_streamer.sv
// -----------------------------------------------------------------------------
// tb_velocity_cell_streamer
// Directed bench: behavioural 1-cycle-latency RAM, sweeps with various counts
// and backpressure, write-back ordering against start, and async reset.
// Cycle numbering: start is driven in cycle 0 and sampled by the next edge;
// cycle k is the period following the k-th edge after that.
// -----------------------------------------------------------------------------
module tb_velocity_cell_streamer;

   localparam int DW = 96;
   localparam int AW = 8;
   localparam int PN = 220;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done;
   logic [AW-1:0] count;
`ifdef VELOCITY_COUNT_CLAMP_EN
   logic          count_err;
`endif
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_pid;
   logic          wb_valid = 1'b0;
   logic          wb_ready;
   logic [AW-1:0] wb_addr = '0;
   logic [DW-1:0] wb_data = '0;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data;
   logic          ram_rden, ram_wren;
   logic [DW-1:0] ram_q = '0;

   logic [DW-1:0] mem [0:255];
   logic          bd_init = 1'b0;
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_data = '0;

   int errors = 0;
   int checks = 0;

   // Sweep results
   logic [AW-1:0] got_pid  [0:299];
   logic [DW-1:0] got_data [0:299];
   int            got_cyc  [0:299];
   int            nw, done_cyc, stab_err, credit_err, both_err, wbr_err;
   logic          ovalid_seen, cyc0_wb_ready, cyc0_wren;

   localparam logic [DW-1:0] WB_WORD = 96'hA123_4567_89AB_CDEF_0F1E_2D3B;

   always #5 clk = ~clk;

   velocity_cell_streamer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .count       (count),
`ifdef VELOCITY_COUNT_CLAMP_EN
      .count_err   (count_err),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_pid     (out_pid),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_rden    (ram_rden),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q)
   );

   function automatic logic [DW-1:0] vel(input int i);
      return {32'h3000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
   endfunction

   // RAM model: synchronous read, one cycle latency; bench backdoor writes.
   always @(posedge clk) begin
      if (ram_rden) ram_q <= mem[ram_address];
      if (bd_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= vel(i);
      end else if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (ram_wren) begin
         mem[ram_address] <= ram_data;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int a, input logic [DW-1:0] d);
      bd_we = 1'b1; bd_addr = AW'(a); bd_data = d;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"},      96'(busy),        96'(0));
      chk({tag, "_done"},      96'(done),        96'(0));
      chk({tag, "_count"},     96'(count),       96'(0));
      chk({tag, "_out_valid"}, 96'(out_valid),   96'(0));
      chk({tag, "_out_data"},  out_data,         96'(0));
      chk({tag, "_out_pid"},   96'(out_pid),     96'(0));
      chk({tag, "_wb_ready"},  96'(wb_ready),    96'(0));
      chk({tag, "_rden"},      96'(ram_rden),    96'(0));
      chk({tag, "_wren"},      96'(ram_wren),    96'(0));
      chk({tag, "_addr"},      96'(ram_address), 96'(0));
      chk({tag, "_ram_data"},  ram_data,         96'(0));
`ifdef VELOCITY_COUNT_CLAMP_EN
      chk({tag, "_count_err"}, 96'(count_err),   96'(0));
`endif
   endtask

   // Pulse start and observe the sweep until done or budget expiry.
   // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating.
   task automatic run_sweep(input int mode, input int budget);
      int            issued, popped;
      logic          pstall, pop_now;
      logic [DW-1:0] pdata;
      logic [AW-1:0] ppid;
      nw = 0; done_cyc = -1; stab_err = 0; credit_err = 0; both_err = 0; wbr_err = 0;
      ovalid_seen = 1'b0; issued = 0; popped = 0; pstall = 1'b0; pdata = '0; ppid = '0;
      start = 1'b1;
      out_ready = (mode == 0);
      #1;
      cyc0_wb_ready = wb_ready;
      cyc0_wren = ram_wren;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
         #1;
         pop_now = out_valid && out_ready;
         if (ram_rden && ram_wren) both_err++;
         if (busy && wb_ready) wbr_err++;
         if (pstall && (!out_valid || out_data !== pdata || out_pid !== ppid)) stab_err++;
         if (ram_rden && busy && ram_address != '0) begin
            if (issued - popped - (pop_now ? 1 : 0) >= 2) credit_err++;
            issued++;
         end
         if (out_valid) ovalid_seen = 1'b1;
         if (pop_now && nw < 300) begin
            got_pid[nw] = out_pid; got_data[nw] = out_data; got_cyc[nw] = cyc;
            nw++; popped++;
         end
         pstall = out_valid && !out_ready;
         pdata = out_data;
         ppid = out_pid;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      chk("sweep_done_seen", 96'(done_cyc >= 0), 96'(1));
   endtask

   initial begin
      // ---------------- reset ----------------
      @(posedge clk); #1;
      bd_init = 1'b1;
      tick();
      bd_init = 1'b0;
      check_reset("rst");
      #2 rst_n = 1'b1;
      tick();
      chk("idle_wb_ready", 96'(wb_ready), 96'(1));

      // ---------------- count = 3, ready high ----------------
      set_word(0, 96'(3));
      run_sweep(0, 40);
      chk("c3_nwords", 96'(nw), 96'(3));
      for (int i = 0; i < 3; i++) begin
         chk("c3_pid",  96'(got_pid[i]), 96'(i + 1));
         chk("c3_data", got_data[i], vel(i + 1));
         chk("c3_cyc",  96'(got_cyc[i]), 96'(4 + i));
      end
      chk("c3_done_cyc", 96'(done_cyc), 96'(7));
      chk("c3_count", 96'(count), 96'(3));
      chk("c3_busy_at_done", 96'(busy), 96'(0));
      chk("c3_credit", 96'(credit_err), 96'(0));
      tick();
      chk("c3_done_pulse", 96'(done), 96'(0));

      // ---------------- count = 5, backpressure ----------------
      set_word(0, 96'(5));
      run_sweep(1, 80);
      chk("c5_nwords", 96'(nw), 96'(5));
      for (int i = 0; i < 5; i++) begin
         chk("c5_pid",  96'(got_pid[i]), 96'(i + 1));
         chk("c5_data", got_data[i], vel(i + 1));
      end
      chk("c5_stable", 96'(stab_err), 96'(0));
      chk("c5_credit", 96'(credit_err), 96'(0));
      chk("c5_rd_wr_excl", 96'(both_err), 96'(0));
      chk("c5_count", 96'(count), 96'(5));

      // ---------------- count = 0 ----------------
      set_word(0, 96'(0));
      run_sweep(0, 20);
      chk("c0_done_cyc", 96'(done_cyc), 96'(3));
      chk("c0_no_valid", 96'(ovalid_seen), 96'(0));
      chk("c0_count", 96'(count), 96'(0));

      // ---------------- write-back racing start ----------------
      set_word(0, 96'(7));
      wb_valid = 1'b1; wb_addr = AW'(7); wb_data = WB_WORD;
      run_sweep(0, 40);
      chk("wb_ready_with_start", 96'(cyc0_wb_ready), 96'(0));
      chk("wb_no_write_with_start", 96'(cyc0_wren), 96'(0));
      chk("wb_ready_busy", 96'(wbr_err), 96'(0));
      chk("wb_old_pid7", got_data[6], vel(7));
      chk("wb_lands_wren", 96'(ram_wren), 96'(1));
      chk("wb_lands_addr", 96'(ram_address), 96'(7));
      chk("wb_lands_data", ram_data, WB_WORD);
      tick();
      wb_valid = 1'b0;
      run_sweep(0, 40);
      chk("wb_reread_n", 96'(nw), 96'(7));
      chk("wb_reread_pid7", got_data[6], WB_WORD);

      // ---------------- out-of-range count ----------------
      set_word(0, 96'(250));
      run_sweep(0, 400);
`ifdef VELOCITY_COUNT_CLAMP_EN
      chk("big_nwords", 96'(nw), 96'(PN - 1));
      chk("big_count", 96'(count), 96'(PN - 1));
      chk("big_count_err", 96'(count_err), 96'(1));
      chk("big_last_pid", 96'(got_pid[PN - 2]), 96'(PN - 1));
      chk("big_done_cyc", 96'(done_cyc), 96'(PN - 1 + 4));
`else
      chk("big_nwords", 96'(nw), 96'(250));
      chk("big_count", 96'(count), 96'(250));
      chk("big_last_pid", 96'(got_pid[249]), 96'(250));
      chk("big_last_data", got_data[249], vel(250));
      chk("big_done_cyc", 96'(done_cyc), 96'(254));
`endif
      chk("big_credit", 96'(credit_err), 96'(0));

      // ---------------- reset mid-STREAM ----------------
      set_word(0, 96'(5));
      start = 1'b1; out_ready = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      chk("mid_busy_before_rst", 96'(busy), 96'(1));
      #2 rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      tick();
      check_reset("held_rst");
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_wb_ready", 96'(wb_ready), 96'(1));
      set_word(0, 96'(3));
      run_sweep(1, 60);
      chk("post_rst_nwords", 96'(nw), 96'(3));
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_pid",  96'(got_pid[i]), 96'(i + 1));
         chk("post_rst_data", got_data[i], vel(i + 1));
      end
      chk("post_rst_stable", 96'(stab_err), 96'(0));
`ifdef VELOCITY_COUNT_CLAMP_EN
      chk("post_rst_count_err", 96'(count_err), 96'(0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
